alu_e_unit: RTL and testbench
=============================

Name: alu_e_unit

Overview:
- Adder-and-logic stage that produces the accumulator's load data (AC_INP) from AC, DR and INPR.
- Owns the E (carry/extend) flip-flop.
- Adds an iterative shift-add multiplier (half-width × half-width → full-width product) with a BUSY/DONE handshake to the control sequencer.
- Sits directly upstream of the accumulator register; the control unit asserts AC LD in the same cycle it selects an op here.

Parameters:
- size, 16, datapath width. Must be even, ≥ 4.
- inpr_w, 8, INPR width. Must be < size.

Ports:
- CLK  input  1  system clock. All state updates on the falling edge, same edge as the accumulator.
- reset  input  1  asynchronous, active-high reset.
- EN  input  1  op strobe; qualifies state effects (E update, multiply start) at the next falling edge.
- OP  input  4  operation select (codes below).
- AC_IN  input  size  current accumulator value.
- DR_IN  input  size  data register value.
- INPR_IN  input  inpr_w  input register value.
- ALU_OUT  output  size  combinational result, wired to the accumulator's AC_INP.
- E_OUT  output  1  E flip-flop.
- BUSY  output  1  multiply in progress.
- DONE  output  1  one-cycle pulse when the product register becomes valid.

Behaviour:
- Reset (async, immediate): E=0, product reg=0, multiplicand/multiplier regs=0, iteration count=0, BUSY=0, DONE=0. Reset mid-multiply aborts the multiply; the product reads 0.
- ALU_OUT is purely combinational from OP, AC_IN, DR_IN, INPR_IN, E and the product reg. It does not depend on EN or BUSY.
- E and multiplier state change only at a falling edge with EN=1 and BUSY=0. EN is ignored entirely while BUSY=1.
- OP codes (ALU_OUT ; E effect when accepted):
  - 0 AND: AC & DR ; E unchanged.
  - 1 ADD: low size bits of AC+DR ; E <= carry-out (bit size of the (size+1)-bit sum).
  - 2 LDR: DR ; E unchanged.
  - 3 INP: {AC[size-1:inpr_w], INPR} ; E unchanged.
  - 4 CMA: ~AC ; E unchanged.
  - 5 CIR: {E, AC[size-1:1]} ; E <= AC[0].
  - 6 CIL: {AC[size-2:0], E} ; E <= AC[size-1].
  - 7 CLE: AC ; E <= 0.
  - 8 CME: AC ; E <= ~E.
  - 9 MUL: AC ; starts a multiply ; E unchanged.
  - 10 MRD: product reg ; E unchanged.
  - 11-15 reserved: AC ; no state effect.
- Multiply sequence, with H = size/2:
  - Start edge (EN=1, OP=9, BUSY=0):
    - mcand <= zero-extended DR[H-1:0]
    - mplier <= AC[H-1:0]
    - product <= 0
    - count <= H
    - BUSY <= 1
  - Each subsequent falling edge while BUSY=1:
    - if mplier[0]=1, product <= product + mcand
    - mcand <<= 1; mplier >>= 1; count <= count-1
    - when count goes 1→0: BUSY <= 0, DONE <= 1
  - Fixed latency: BUSY high for exactly H cycles; DONE high for exactly one cycle after the last iteration. No early termination.
  - Product is unsigned, exactly size bits, no overflow possible. It holds until the next start or reset.
  - DONE deasserts on the next falling edge regardless of EN.
  - A start in the same cycle DONE=1 is accepted (BUSY=0). The new multiply clears the product.
- Arithmetic wrap: ADD 0xFFFF+0x0001 gives ALU_OUT=0x0000, E=1. No saturation anywhere.
- Reset asserted together with EN: reset wins.

Decomposition:
- Shared package/header holds the OP code constants (AND … MRD) and the default size/inpr_w. The control-unit decoder reuses them.
- One sub-module is natural: shift_add_mul. It holds the mcand/mplier/product/count registers and the BUSY/DONE logic, with a start input and a product output.
- The top level keeps the combinational op mux and the E flip-flop.

Test Plan:
- Reset, then EN OP=1 with AC=0xFFFF, DR=0x0001 → ALU_OUT=0x0000; E_OUT=1 after the falling edge.
- Then with E=1: EN OP=5 with AC=0x0002 → ALU_OUT=0x8001, E→0. Then EN OP=6 with AC=0x8001, E=0 → ALU_OUT=0x0002, E→1.
- EN OP=3 with AC=0xABCD, INPR=0x5A → ALU_OUT=0xAB5A, E unchanged. EN OP=8 twice → E toggles and returns to its original value. EN OP=7 → E=0.
- EN OP=9 with AC=0x12FF, DR=0x34FF:
  - BUSY high for 8 cycles, then DONE pulses for 1 cycle.
  - OP=10 then gives ALU_OUT=0xFE01.
  - Repeat with AC=0x0000 → product 0x0000 with the same latency.
- During a multiply, EN OP=8 and EN OP=9 are both ignored: E unchanged, product from the first multiply correct, latency unchanged.
- Assert reset at the 4th BUSY cycle of a multiply → BUSY=0, DONE=0, E=0, and OP=10 gives ALU_OUT=0x0000 immediately.

Source files
------------

// File: rtl/alu_e_unit_pkg.sv
// Shared definitions for the AC load-data stage: op codes, default widths and
// the multiplier sequencer state type. The control-unit decoder imports this too.
package alu_e_unit_pkg;

    localparam int DEFAULT_SIZE   = 16;
    localparam int DEFAULT_INPR_W = 8;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDR = 4'd2;
    localparam logic [3:0] OP_INP = 4'd3;
    localparam logic [3:0] OP_CMA = 4'd4;
    localparam logic [3:0] OP_CIR = 4'd5;
    localparam logic [3:0] OP_CIL = 4'd6;
    localparam logic [3:0] OP_CLE = 4'd7;
    localparam logic [3:0] OP_CME = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_MRD = 4'd10;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/alu_e_unit_if.sv
// Control-sequencer side of alu_e_unit: op strobe and operands in, AC load
// data, E, and multiply handshake out.
interface alu_e_unit_if
    import alu_e_unit_pkg::*;
#(
    parameter int size   = DEFAULT_SIZE,
    parameter int inpr_w = DEFAULT_INPR_W
);
    // Handshake: EN with OP is accepted at a falling edge only while BUSY=0.
    // A MUL accept raises BUSY for size/2 cycles, then DONE pulses for one
    // cycle as the product becomes readable through OP=MRD.
    logic              EN;
    logic [3:0]        OP;
    logic [size-1:0]   AC_IN;
    logic [size-1:0]   DR_IN;
    logic [inpr_w-1:0] INPR_IN;
    logic [size-1:0]   ALU_OUT;
    logic              E_OUT;
    logic              BUSY;
    logic              DONE;
    mul_state_e        mul_state;

    modport master (
        output EN, OP, AC_IN, DR_IN, INPR_IN,
        input  ALU_OUT, E_OUT, BUSY, DONE, mul_state
    );

    modport slave (
        input  EN, OP, AC_IN, DR_IN, INPR_IN,
        output ALU_OUT, E_OUT, BUSY, DONE, mul_state
    );
endinterface

// File: rtl/alu_e_unit_shift_add_mul.sv
// Iterative shift-add multiplier: half-width x half-width -> full-width
// unsigned product, fixed latency of size/2 cycles, falling-edge clocked.
module shift_add_mul
    import alu_e_unit_pkg::*;
#(
    parameter int size = DEFAULT_SIZE
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic [size/2-1:0]   mplier_in,
    input  logic [size/2-1:0]   mcand_in,
    output logic [size-1:0]     product,
    output logic                busy,
    output logic                done,
    output mul_state_e          state
);
    localparam int H  = size / 2;
    localparam int CW = $clog2(H + 1);

    logic [size-1:0] mcand;
    logic [H-1:0]    mplier;
    logic [CW-1:0]   count;

    always_ff @(negedge CLK or posedge reset) begin
        if (reset) begin
            state   <= MUL_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand   <= {{H{1'b0}}, mcand_in};
                        mplier  <= mplier_in;
                        product <= '0;
                        count   <= CW'(H);
                        busy    <= 1'b1;
                        state   <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand  <= {mcand[size-2:0], 1'b0};
                    mplier <= {1'b0, mplier[H-1:1]};
                    count  <= count - CW'(1);
                    // Last iteration: the product update above lands on this edge.
                    if (count == CW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= MUL_IDLE;
                    end
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alu_e_unit.sv
// Adder-and-logic stage producing the accumulator load data; owns the E
// flip-flop and fronts the shift-add multiplier.
module alu_e_unit
    import alu_e_unit_pkg::*;
#(
    parameter int size   = DEFAULT_SIZE,
    parameter int inpr_w = DEFAULT_INPR_W
) (
    input  logic       CLK,
    input  logic       reset,
    alu_e_unit_if.slave bus
);
    localparam int H = size / 2;

    generate
        if ((size % 2) != 0 || size < 4) begin : g_bad_size
            $error("alu_e_unit: size must be even and at least 4");
        end
        if (inpr_w >= size) begin : g_bad_inpr
            $error("alu_e_unit: inpr_w must be smaller than size");
        end
    endgenerate

    logic            e_q;
    logic            accept;
    logic            mul_start;
    logic [size:0]   sum;
    logic [size-1:0] product;
    logic [size-1:0] alu_out;

    // EN is meaningless while a multiply runs; nothing may disturb E then.
    assign accept    = bus.EN && !bus.BUSY;
    assign mul_start = accept && (bus.OP == OP_MUL);
    assign sum       = {1'b0, bus.AC_IN} + {1'b0, bus.DR_IN};

    always_comb begin
        alu_out = bus.AC_IN;
        case (bus.OP)
            OP_AND:  alu_out = bus.AC_IN & bus.DR_IN;
            OP_ADD:  alu_out = sum[size-1:0];
            OP_LDR:  alu_out = bus.DR_IN;
            OP_INP:  alu_out = {bus.AC_IN[size-1:inpr_w], bus.INPR_IN};
            OP_CMA:  alu_out = ~bus.AC_IN;
            OP_CIR:  alu_out = {e_q, bus.AC_IN[size-1:1]};
            OP_CIL:  alu_out = {bus.AC_IN[size-2:0], e_q};
            OP_MRD:  alu_out = product;
            default: alu_out = bus.AC_IN;
        endcase
    end

    always_ff @(negedge CLK or posedge reset) begin
        if (reset) begin
            e_q <= 1'b0;
        end else if (accept) begin
            case (bus.OP)
                OP_ADD:  e_q <= sum[size];
                OP_CIR:  e_q <= bus.AC_IN[0];
                OP_CIL:  e_q <= bus.AC_IN[size-1];
                OP_CLE:  e_q <= 1'b0;
                OP_CME:  e_q <= ~e_q;
                default: e_q <= e_q;
            endcase
        end
    end

    shift_add_mul #(.size(size)) u_mul (
        .CLK       (CLK),
        .reset     (reset),
        .start     (mul_start),
        .mplier_in (bus.AC_IN[H-1:0]),
        .mcand_in  (bus.DR_IN[H-1:0]),
        .product   (product),
        .busy      (bus.BUSY),
        .done      (bus.DONE),
        .state     (bus.mul_state)
    );

    assign bus.ALU_OUT = alu_out;
    assign bus.E_OUT   = e_q;
endmodule

// File: tb/tb_alu_e_unit.sv
// Bench for alu_e_unit: op table with expected ALU_OUT/E, plus multiply
// sequences checked against a product scoreboard.
module tb_alu_e_unit;
    import alu_e_unit_pkg::*;

    localparam int W = 16;

    logic CLK;
    logic reset;

    alu_e_unit_if #(.size(W), .inpr_w(8)) bus_i ();

    alu_e_unit #(.size(W), .inpr_w(8)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_i.slave)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic       en;
        logic [3:0] op;
        logic [W-1:0] ac;
        logic [W-1:0] dr;
        logic [7:0] inpr;
        logic [W-1:0] exp_alu;
        logic       exp_e;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] op, input logic [W-1:0] ac,
                         input logic [W-1:0] dr, input logic [7:0] inpr);
        bus_i.EN      = en;
        bus_i.OP      = op;
        bus_i.AC_IN   = ac;
        bus_i.DR_IN   = dr;
        bus_i.INPR_IN = inpr;
    endtask

    // Accept a multiply at the next falling edge and record the expected product.
    task automatic start_mul(input logic [W-1:0] ac, input logic [W-1:0] dr);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = {8'h00, ac[7:0]};
        b = {8'h00, dr[7:0]};
        exp_q.push_back(W'(a * b));
        drive(1'b1, OP_MUL, ac, dr, 8'h00);
        settle();
        bus_i.EN = 1'b0;
    endtask

    // Called at the first sample after a start edge; returns at the DONE sample
    // with the product already compared through OP=MRD.
    task automatic wait_mul(input string tag, input bit inject, output logic [W-1:0] got);
        int  busy_cnt;
        bit  seen_done;
        logic [W-1:0] exp;
        busy_cnt  = 0;
        seen_done = 0;
        got       = '0;
        for (int c = 0; c < 20; c++) begin
            if (bus_i.DONE) begin
                seen_done = 1;
                break;
            end
            if (bus_i.BUSY) busy_cnt++;
            if (inject && busy_cnt == 2) drive(1'b1, OP_CME, 16'h0000, 16'h0000, 8'h00);
            else if (inject && busy_cnt == 3) drive(1'b1, OP_MUL, 16'hFFFF, 16'hFFFF, 8'h00);
            else bus_i.EN = 1'b0;
            settle();
        end
        bus_i.EN = 1'b0;
        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_busy_low_at_done"}, 32'(bus_i.BUSY), 32'd0);
        bus_i.OP = OP_MRD;
        #1;
        got = bus_i.ALU_OUT;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_product"}, 32'(bus_i.ALU_OUT), 32'(exp));
        end else begin
            check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
        end
    endtask

    logic [W-1:0] got;
    logic         e_before;

    initial begin
        vecs[0]  = '{1'b1, OP_MRD, 16'h1111, 16'h2222, 8'h00, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, OP_ADD, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 1'b1};
        vecs[2]  = '{1'b1, OP_CIR, 16'h0002, 16'h0000, 8'h00, 16'h8001, 1'b0};
        vecs[3]  = '{1'b1, OP_CIL, 16'h8001, 16'h0000, 8'h00, 16'h0002, 1'b1};
        vecs[4]  = '{1'b1, OP_INP, 16'hABCD, 16'h0000, 8'h5A, 16'hAB5A, 1'b1};
        vecs[5]  = '{1'b1, OP_CME, 16'h1234, 16'h0000, 8'h00, 16'h1234, 1'b0};
        vecs[6]  = '{1'b1, OP_CME, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, OP_CLE, 16'h5555, 16'h0000, 8'h00, 16'h5555, 1'b0};
        vecs[8]  = '{1'b1, OP_AND, 16'hF0F0, 16'h3C3C, 8'h00, 16'h3030, 1'b0};
        vecs[9]  = '{1'b1, OP_LDR, 16'h0000, 16'hBEEF, 8'h00, 16'hBEEF, 1'b0};
        vecs[10] = '{1'b1, OP_CMA, 16'h00FF, 16'h0000, 8'h00, 16'hFF00, 1'b0};
        vecs[11] = '{1'b1, OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 1'b0};
        vecs[12] = '{1'b1, OP_ADD, 16'h8000, 16'h8001, 8'h00, 16'h0001, 1'b1};
        vecs[13] = '{1'b1, 4'd12,  16'h1357, 16'hFFFF, 8'h00, 16'h1357, 1'b1};
        vecs[14] = '{1'b0, OP_ADD, 16'hFFFF, 16'hFFFF, 8'h00, 16'hFFFE, 1'b1};
        vecs[15] = '{1'b0, OP_CIL, 16'h8000, 16'h0000, 8'h00, 16'h0001, 1'b1};
        vecs[16] = '{1'b1, OP_CLE, 16'h2468, 16'h0000, 8'h00, 16'h2468, 1'b0};

        // Clock and reset
        reset = 1'b1;
        drive(1'b0, OP_MRD, 16'h0000, 16'h0000, 8'h00);
        #22;
        reset = 1'b0;
        settle();
        check("reset_e", 32'(bus_i.E_OUT), 32'd0);
        check("reset_busy", 32'(bus_i.BUSY), 32'd0);
        check("reset_done", 32'(bus_i.DONE), 32'd0);
        check("reset_product", 32'(bus_i.ALU_OUT), 32'd0);

        // Single-cycle op table
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].op, vecs[i].ac, vecs[i].dr, vecs[i].inpr);
            #1;
            check($sformatf("vec%0d_alu", i), 32'(bus_i.ALU_OUT), 32'(vecs[i].exp_alu));
            settle();
            check($sformatf("vec%0d_e", i), 32'(bus_i.E_OUT), 32'(vecs[i].exp_e));
        end
        bus_i.EN = 1'b0;

        // Multiply with all-ones low bytes
        start_mul(16'h12FF, 16'h34FF);
        wait_mul("mul_ff", 1'b0, got);
        settle();
        check("mul_ff_done_pulse_end", 32'(bus_i.DONE), 32'd0);
        check("mul_ff_product_held", 32'(bus_i.ALU_OUT), 32'h0000FE01);

        // Zero multiplier, same latency
        start_mul(16'h0000, 16'h34FF);
        wait_mul("mul_zero", 1'b0, got);
        settle();

        // EN traffic during a multiply is ignored
        e_before = bus_i.E_OUT;
        start_mul(16'h0037, 16'h00C5);
        wait_mul("mul_ignore", 1'b1, got);
        check("mul_ignore_e", 32'(bus_i.E_OUT), 32'(e_before));

        // Back-to-back start on the DONE cycle
        check("chain_done_high", 32'(bus_i.DONE), 32'd1);
        start_mul(16'h00A5, 16'h005A);
        bus_i.OP = OP_MRD;
        #1;
        check("chain_product_cleared", 32'(bus_i.ALU_OUT), 32'd0);
        check("chain_done_low", 32'(bus_i.DONE), 32'd0);
        wait_mul("mul_chain", 1'b0, got);
        settle();

        // Reset in the middle of a multiply, with E set beforehand
        drive(1'b1, OP_CME, 16'h0000, 16'h0000, 8'h00);
        settle();
        bus_i.EN = 1'b0;
        check("pre_abort_e", 32'(bus_i.E_OUT), 32'd1);
        start_mul(16'h00FF, 16'h00FF);
        for (int k = 1; k < 4; k++) settle();
        check("abort_busy_before", 32'(bus_i.BUSY), 32'd1);
        drive(1'b1, OP_CME, 16'h0000, 16'h0000, 8'h00);
        reset = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("abort_busy", 32'(bus_i.BUSY), 32'd0);
        check("abort_done", 32'(bus_i.DONE), 32'd0);
        check("abort_e", 32'(bus_i.E_OUT), 32'd0);
        bus_i.OP = OP_MRD;
        #1;
        check("abort_product", 32'(bus_i.ALU_OUT), 32'd0);
        // Reset held across an edge with EN asserted: reset wins
        bus_i.OP = OP_CME;
        settle();
        check("reset_beats_en_e", 32'(bus_i.E_OUT), 32'd0);
        bus_i.EN = 1'b0;
        reset = 1'b0;
        settle();
        check("post_abort_busy", 32'(bus_i.BUSY), 32'd0);
        bus_i.OP = OP_MRD;
        #1;
        check("post_abort_product", 32'(bus_i.ALU_OUT), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
